// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and sizing constants.
package loader_pkg;

  localparam int ADDR_W_DEFAULT = 10;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader, grouped as one bundle.
interface instr_loader_if
  import loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) ();

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic              mem_bank;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_bank, mem_addr, mem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_bank, mem_addr, mem_wdata
  );

endinterface

// File: rtl/instr_loader_word_packer.sv
// Assembles four accepted bytes into a little-endian 32-bit word and flags the completing byte.
module word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_full
);

  localparam logic [1:0] LAST_BYTE_C = 2'(BYTES_PER_WORD - 1);

  logic [31:0] word_r;
  logic [31:0] word_next_s;
  logic [1:0]  cnt_r;
  logic [1:0]  cnt_next_s;

  // Shift each byte in from the top so the first byte ends up in bits 7:0
  always_comb begin
    word_next_s = word_r;
    cnt_next_s  = cnt_r;
    if (clr) begin
      word_next_s = 32'h0000_0000;
      cnt_next_s  = 2'd0;
    end else if (in_valid) begin
      word_next_s = {in_data, word_r[31:8]};
      cnt_next_s  = cnt_r + 2'd1;
    end else begin
      word_next_s = word_r;
      cnt_next_s  = cnt_r;
    end
  end

  // Byte-assembly registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_r <= 32'h0000_0000;
      cnt_r  <= 2'd0;
    end else begin
      word_r <= word_next_s;
      cnt_r  <= cnt_next_s;
    end
  end

  assign word      = word_next_s;
  assign word_full = in_valid & (cnt_r == LAST_BYTE_C);

endmodule

// File: rtl/instr_loader.sv
// Streams bytes into instruction memory as 32-bit words and holds the core's fetch PC
// while loading, restarting it once a load completes.
module instr_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ADDR_W:0] num_words,
  input  logic            bank_sel,
  input  logic            abort,
  instr_loader_if.master  bus,
  output logic            core_en,
  output logic            core_rst,
  output logic            busy,
  output logic            done
);

  localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_r;
  state_e            state_next_s;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   word_cnt_r;
  logic [ADDR_W:0]   count_clamp_s;
  logic              accept_s;
  logic              start_ok_s;
  logic              packer_clr_s;
  logic              word_full_s;
  logic [31:0]       word_s;
  logic              byte_ready_r;
  logic              we_r;
  logic              bank_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic              core_en_r;
  logic              core_rst_r;
  logic              busy_r;
  logic              done_r;

  assign accept_s     = bus.byte_valid & byte_ready_r;
  assign start_ok_s   = start & (state_r == ST_IDLE);
  assign packer_clr_s = (state_next_s == ST_IDLE);

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (packer_clr_s),
    .in_valid  (accept_s),
    .in_data   (bus.byte_data),
    .word      (word_s),
    .word_full (word_full_s)
  );

  // Oversized requests are limited to the memory depth
  always_comb begin
    if (num_words > DEPTH_C) begin
      count_clamp_s = DEPTH_C;
    end else begin
      count_clamp_s = num_words;
    end
  end

  // Next-state logic; abort wins over any transition out of RECV or WRITE
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (count_clamp_s == ZERO_C) state_next_s = ST_DONE;
          else                         state_next_s = ST_RECV;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (abort)            state_next_s = ST_IDLE;
        else if (word_full_s) state_next_s = ST_WRITE;
        else                  state_next_s = ST_RECV;
      end
      ST_WRITE: begin
        if (abort)                             state_next_s = ST_IDLE;
        else if (word_cnt_r == count_r - ONE_C) state_next_s = ST_DONE;
        else                                   state_next_s = ST_RECV;
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, latched request parameters and word counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      count_r    <= ZERO_C;
      bank_r     <= 1'b0;
      word_cnt_r <= ZERO_C;
    end else begin
      state_r <= state_next_s;
      if (start_ok_s) begin
        count_r <= count_clamp_s;
        bank_r  <= bank_sel;
      end
      if (state_r == ST_IDLE) begin
        word_cnt_r <= ZERO_C;
      end else if (state_r == ST_WRITE) begin
        word_cnt_r <= word_cnt_r + ONE_C;
      end
    end
  end

  // Outputs are registered from the next state so each one is aligned with its state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_ready_r <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= 32'h0000_0000;
      core_en_r    <= 1'b1;
      core_rst_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      byte_ready_r <= (state_next_s == ST_RECV);
      we_r         <= (state_next_s == ST_WRITE);
      core_en_r    <= (state_next_s == ST_IDLE);
      core_rst_r   <= (state_next_s == ST_DONE);
      busy_r       <= (state_next_s != ST_IDLE);
      done_r       <= (state_next_s == ST_DONE);
      if (state_next_s == ST_WRITE) begin
        addr_r  <= word_cnt_r[ADDR_W-1:0];
        wdata_r <= word_s;
      end
    end
  end

  // Abort arriving during the WRITE cycle must still cancel that write
  assign bus.mem_we     = we_r & ~abort;
  assign bus.byte_ready = byte_ready_r;
  assign bus.mem_bank   = bank_r;
  assign bus.mem_addr   = addr_r;
  assign bus.mem_wdata  = wdata_r;
  assign core_en        = core_en_r;
  assign core_rst       = core_rst_r;
  assign busy           = busy_r;
  assign done           = done_r;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: stimulus pushes expected writes/done pulses into queues,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_instr_loader;
  import loader_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic          bank;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [AW:0] num_words;
  logic        bank_sel;
  logic        abort;
  logic        core_en;
  logic        core_rst;
  logic        busy;
  logic        done;

  instr_loader_if #(.ADDR_W(AW)) bus ();

  instr_loader #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_words (num_words),
    .bank_sel  (bank_sel),
    .abort     (abort),
    .bus       (bus),
    .core_en   (core_en),
    .core_rst  (core_rst),
    .busy      (busy),
    .done      (done)
  );

  wr_t exp_wr[$];
  bit  exp_done[$];   // 1 = also check done arrives one cycle after the last write
  int  compared = 0;
  int  mismatched = 0;
  int  cyc = 0;
  int  last_xfer_cyc = 0;
  int  last_we_cyc = 0;
  int  xfer_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic flag(input string msg);
    compared++;
    mismatched++;
    $display("FAIL %s", msg);
  endtask

  // Cycle counter and accepted-transfer log
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && bus.byte_valid && bus.byte_ready) begin
      xfer_cnt      <= xfer_cnt + 1;
      last_xfer_cyc <= cyc;
    end
  end

  // Monitor: every write and every done pulse must match the head of the scoreboard
  always @(negedge clk) begin
    wr_t e;
    bit  lat;
    if (rst && bus.mem_we) begin
      last_we_cyc <= cyc;
      if (exp_wr.size() == 0) begin
        flag($sformatf("unexpected_write: addr %h data %h, required no write", bus.mem_addr, bus.mem_wdata));
      end else begin
        e = exp_wr.pop_front();
        check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
        check("wr_data", bus.mem_wdata, e.data);
        check("wr_bank", 32'(bus.mem_bank), 32'(e.bank));
        check("wr_latency", 32'(cyc - last_xfer_cyc), 32'd1);
      end
    end
    if (rst && (done || core_rst)) begin
      check("core_rst_with_done", 32'(core_rst), 32'(done));
      check("core_en_in_done", 32'(core_en), 32'd0);
      if (exp_done.size() == 0) begin
        flag("unexpected_done: got a done pulse, required none");
      end else begin
        lat = exp_done.pop_front();
        if (lat) check("done_latency", 32'(cyc - last_we_cyc), 32'd1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n, input logic b);
    @(posedge clk); #1;
    start     = 1'b1;
    num_words = n[AW:0];
    bank_sel  = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(negedge clk);
    while (!bus.byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.byte_ready) begin
      flag($sformatf("byte_ready_timeout: byte %h never accepted", b));
      bus.byte_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      bus.byte_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gappy);
    logic [31:0] v;
    v = w;
    for (int k = 0; k < 4; k++) begin
      if (gappy) repeat ($urandom_range(0, 2)) begin
        bus.byte_valid = 1'b0;
        @(posedge clk); #1;
      end
      send_byte(v[7:0]);
      v = v >> 8;
    end
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!done) flag($sformatf("%s_done_timeout: done never pulsed", name));
    @(posedge clk); #1;
    check({name, "_core_en_after"}, 32'(core_en), 32'd1);
    check({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] clamp_word(input int i);
    return {8'(i * 7), 8'hA5, 16'(i)};
  endfunction

  task automatic push_wr(input logic b, input int a, input logic [31:0] d);
    wr_t e;
    e.bank = b;
    e.addr = a[AW-1:0];
    e.data = d;
    exp_wr.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_mem_bank"}, 32'(bus.mem_bank), 32'd0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_core_en"}, 32'(core_en), 32'd1);
    check({tag, "_core_rst"}, 32'(core_rst), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; num_words = '0; bank_sel = 1'b0; abort = 1'b0;
    bus.byte_valid = 1'b0; bus.byte_data = 8'h00;
    #1 rst = 1'b0;
    #2 check_reset_outputs("reset");
    @(negedge clk); rst = 1'b1;
    tick(2);

    // Basic two-word load into bank 1
    push_wr(1'b1, 0, 32'h1234_5678);
    push_wr(1'b1, 1, 32'hDEAD_BEEF);
    exp_done.push_back(1'b1);
    do_start(2, 1'b1);
    check("busy_loading", 32'(busy), 32'd1);
    check("core_en_loading", 32'(core_en), 32'd0);
    send_word(32'h1234_5678, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    wait_done("basic");

    // Three words with random gaps in byte_valid
    base = xfer_cnt;
    push_wr(1'b0, 0, 32'hA1B2_C3D4);
    push_wr(1'b0, 1, 32'h0F1E_2D3C);
    push_wr(1'b0, 2, 32'h5566_7788);
    exp_done.push_back(1'b1);
    do_start(3, 1'b0);
    send_word(32'hA1B2_C3D4, 1'b1);
    send_word(32'h0F1E_2D3C, 1'b1);
    send_word(32'h5566_7788, 1'b1);
    wait_done("gaps");
    check("gap_transfers", 32'(xfer_cnt - base), 32'd12);

    // Zero-length load goes straight to DONE
    exp_done.push_back(1'b0);
    do_start(0, 1'b0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_core_rst", 32'(core_rst), 32'd1);
    tick(3);

    // Oversized request is clamped to DEPTH words
    for (int i = 0; i < DEPTH; i++) push_wr(1'b1, i, clamp_word(i));
    exp_done.push_back(1'b1);
    do_start(DEPTH + 5, 1'b1);
    for (int i = 0; i < DEPTH; i++) send_word(clamp_word(i), 1'b0);
    wait_done("clamp");

    // Abort after six bytes of a four-word load, then a clean reload
    push_wr(1'b0, 0, 32'h4433_2211);
    do_start(4, 1'b0);
    send_word(32'h4433_2211, 1'b0);
    send_byte(8'h55);
    send_byte(8'h66);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_byte_ready", 32'(bus.byte_ready), 32'd0);
    tick(3);
    push_wr(1'b0, 0, 32'hCAFE_F00D);
    exp_done.push_back(1'b1);
    do_start(1, 1'b0);
    send_word(32'hCAFE_F00D, 1'b0);
    wait_done("reload");

    // Abort during the WRITE cycle suppresses that write
    do_start(2, 1'b1);
    send_word(32'h0102_0304, 1'b0);
    abort = 1'b1;
    #1 check("abort_write_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_write_busy", 32'(busy), 32'd0);
    tick(3);

    // start pulsed mid-load is ignored
    push_wr(1'b1, 0, 32'h0BAD_C0DE);
    push_wr(1'b1, 1, 32'h600D_F00D);
    exp_done.push_back(1'b1);
    do_start(2, 1'b1);
    send_byte(8'hDE);
    start = 1'b1; num_words = 11'd5; bank_sel = 1'b0;
    send_byte(8'hC0);
    start = 1'b0;
    send_byte(8'hAD);
    send_byte(8'h0B);
    send_word(32'h600D_F00D, 1'b0);
    wait_done("start_ignored");

    // Asynchronous reset between bytes 2 and 3
    do_start(1, 1'b1);
    send_byte(8'h11);
    send_byte(8'h22);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk); rst = 1'b1;
    tick(5);
    check("post_reset_busy", 32'(busy), 32'd0);

    tick(2);
    check("sb_writes_left", 32'(exp_wr.size()), 32'd0);
    check("sb_done_left", 32'(exp_done.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory word-address width; DEPTH = 2**ADDR_W words.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  reset is asynchronous and active-low.
REQ-004 start  input  1  one-cycle load request, sampled only in IDLE.
REQ-005 num_words  input  ADDR_W+1  words to load, latched on accepted start.
REQ-006 bank_sel  input  1  target ROM bank (0 = ROM1, 1 = ROM2), latched on accepted start.
REQ-007 abort  input  1  cancels a load in progress.
REQ-008 byte_valid  input  1  upstream byte present.
REQ-009 byte_data  input  8  upstream byte.
REQ-010 byte_ready  output  1  loader can accept a byte.
REQ-011 mem_we  output  1  instruction-memory write strobe.
REQ-012 mem_bank  output  1  latched bank_sel, qualifies mem_we.
REQ-013 mem_addr  output  ADDR_W  write word address.
REQ-014 mem_wdata  output  32  write data.
REQ-015 core_en  output  1  enable for the fetch PC register; 0 while loading.
REQ-016 core_rst  output  1  one-cycle pulse, restarts fetch PC at 0 after a completed load.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 done  output  1  one-cycle pulse on successful completion.

Function
REQ-019 FSM states: IDLE, RECV, WRITE, DONE.
REQ-020 IDLE: core_en=1, byte_ready=0, mem_we=0.
  - start with num_words>0 -> RECV.
  - start with num_words==0 -> DONE.
  - Word and byte counters clear to 0.
REQ-021 num_words > DEPTH is clamped to DEPTH at latch time.
REQ-022 RECV: byte_ready=1, core_en=0.
  - Transfer occurs when byte_valid and byte_ready are both 1.
  - Bytes pack little-endian: 1st byte -> bits 7:0, 4th byte -> bits 31:24.
  - 2-bit byte counter; the 4th transfer -> WRITE.
REQ-023 WRITE lasts exactly one cycle.
  - mem_we=1, mem_addr=word counter, mem_wdata=packed word, byte_ready=0.
  - Word counter increments.
  - If word counter == latched count-1 -> DONE, else -> RECV.
REQ-024 Latency: 4th byte accepted in cycle N -> mem_we in N+1 -> done and core_rst in N+2 for the final word.
REQ-025 DONE lasts one cycle: done=1, core_rst=1, core_en=0; next state IDLE.
REQ-026 start while busy is ignored; latched num_words and bank are unchanged.
REQ-027 abort in RECV or WRITE -> IDLE next cycle.
  - Abort beats a same-cycle write: mem_we=0.
  - No done or core_rst pulse.
  - Partial word is discarded; memory already written keeps its contents.
REQ-028 abort in IDLE or DONE has no effect.
REQ-029 byte_valid while byte_ready=0 transfers nothing; no byte is lost or duplicated.
REQ-030 Load of DEPTH words writes addresses 0..DEPTH-1; the word counter never wraps to 0 before DONE.
REQ-031 mem_addr, mem_wdata and mem_bank are don't-care when mem_we=0 but hold their last values (no toggling).

Reset
REQ-032 rst low forces IDLE asynchronously, regardless of current state.
REQ-033 Reset values: byte_ready=0, mem_we=0, mem_bank=0, mem_addr=0, mem_wdata=0, core_en=1, core_rst=0, busy=0, done=0; counters and latched count = 0.
REQ-034 Reset mid-load behaves like abort but takes effect immediately, with no write in progress completing.

Structure
REQ-035 Shared package loader_pkg holds:
  - the state enum;
  - the default ADDR_W;
  - BYTES_PER_WORD = 4.
REQ-036 One sub-module, word_packer: a 4-byte little-endian shift/assemble register with byte counter and word_full flag; the FSM stays in instr_loader.

Verification
REQ-037 Basic load: start, num_words=2, bank_sel=1; bytes 78 56 34 12 EF BE AD DE.
  - Expect mem_we to 0x12345678 @0, then to 0xDEADBEEF @1, mem_bank=1.
  - Then done and core_rst for one cycle each; core_en returns to 1.
REQ-038 Backpressure/gaps: byte_valid toggled randomly during a 3-word load -> same 3 words written, exactly 12 transfers counted.
REQ-039 Zero and clamp cases:
  - num_words=0 -> DONE the cycle after start, no mem_we.
  - num_words=DEPTH+5 -> exactly DEPTH writes, last at DEPTH-1.
REQ-040 Abort after 6 bytes of a 4-word load:
  - Only word 0 written; no done.
  - Next start with num_words=1 loads correctly from address 0.
REQ-041 Async reset asserted between bytes 2 and 3 -> outputs reach reset values without a clock edge; no mem_we afterwards.
REQ-042 start pulsed during RECV -> ignored; load completes with the originally latched count.
